// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running counter: locks onto a +1 sequence,
// counts wrap-arounds and flags any break with a sticky error.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] y_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             error,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       good_run;
    logic [WIDTH-1:0] prev_inc;
    logic             match;
    logic             wrap;

    // Increment is evaluated in WIDTH bits so the all-ones value predicts zero.
    assign prev_inc = prev + WIDTH'(1);
    assign match    = (y_in == prev_inc);
    assign wrap     = match && (prev == '1);

    // NOTE: every register here is sequential state, so only non-blocking
    // assignments are used; blocking ones would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            good_run   <= '0;
            locked     <= 1'b0;
            error      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
            expected   <= '0;
        end else begin
            wrap_pulse <= 1'b0;
            if (en) begin
                prev     <= y_in;
                expected <= y_in + WIDTH'(1);
                unique case (state)
                    IDLE: begin
                        good_run <= '0;
                        state    <= SYNC;
                        locked   <= 1'b0;
                    end
                    SYNC: begin
                        if (match) begin
                            good_run <= good_run + 4'd1;
                            if (good_run + 4'd1 == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            if (wrap) begin
                                wrap_pulse <= 1'b1;
                                wrap_count <= wrap_count + 1'b1;
                            end
                        end else begin
                            state  <= FAULT;
                            locked <= 1'b0;
                            error  <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (!match && err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        // A clear wins over a simultaneous mismatch, which is still counted.
                        if (clear_err) begin
                            state    <= SYNC;
                            error    <= 1'b0;
                            good_run <= '0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed phases plus random
// traffic, compared every cycle against a behavioural sequence model.
module tb_count_seq_checker;

    localparam int W = 4;
    localparam int C = 8;
    localparam int L = 2;

    localparam int M_IDLE   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_LOCKED = 2;
    localparam int M_FAULT  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] y_in = '0;
    logic         clear_err = 1'b0;
    logic         locked;
    logic         error;
    logic         wrap_pulse;
    logic [C-1:0] wrap_count;
    logic [C-1:0] err_count;
    logic [W-1:0] expected;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode = M_IDLE;
    int m_prev = 0;
    int m_run  = 0;
    int m_err  = 0;
    int m_wp   = 0;
    int m_wc   = 0;
    int m_ec   = 0;
    int m_exp  = 0;

    count_seq_checker #(.WIDTH(W), .CNT_W(C), .LOCK_CNT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .y_in       (y_in),
        .clear_err  (clear_err),
        .locked     (locked),
        .error      (error),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .err_count  (err_count),
        .expected   (expected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Model of the monitor's rules: a sample is good when it is the previous
    // sample plus one modulo 16.
    task automatic model(input bit r, input bit e, input int y, input bit c);
        bit good;
        if (r) begin
            m_mode = M_IDLE; m_prev = 0; m_run = 0; m_err = 0;
            m_wp = 0; m_wc = 0; m_ec = 0; m_exp = 0;
            return;
        end
        m_wp = 0;
        if (!e) return;
        good = (y == (m_prev + 1) % 16);
        if (m_mode == M_IDLE) begin
            m_run  = 0;
            m_mode = M_SYNC;
        end else if (m_mode == M_SYNC) begin
            if (good) begin
                m_run++;
                if (m_run == L) m_mode = M_LOCKED;
            end else begin
                m_run = 0;
            end
        end else if (m_mode == M_LOCKED) begin
            if (good) begin
                if (m_prev == 15) begin
                    m_wp = 1;
                    m_wc = (m_wc + 1) % 256;
                end
            end else begin
                m_mode = M_FAULT;
                m_err  = 1;
                if (m_ec < 255) m_ec++;
            end
        end else begin
            if (!good && m_ec < 255) m_ec++;
            if (c) begin
                m_mode = M_SYNC;
                m_err  = 0;
                m_run  = 0;
            end
        end
        m_prev = y;
        m_exp  = (y + 1) % 16;
    endtask

    task automatic check_all();
        check("locked",     int'(locked),     int'(m_mode == M_LOCKED));
        check("error",      int'(error),      m_err);
        check("wrap_pulse", int'(wrap_pulse), m_wp);
        check("wrap_count", int'(wrap_count), m_wc);
        check("err_count",  int'(err_count),  m_ec);
        check("expected",   int'(expected),   m_exp);
    endtask

    // Apply one set of inputs, let one rising edge pass, then compare.
    task automatic step(input bit r, input bit e, input int y, input bit c);
        reset     = r;
        en        = e;
        y_in      = W'(y);
        clear_err = c;
        @(posedge clk);
        #1;
        model(r, e, y, c);
        check_all();
    endtask

    initial begin
        int cnt;
        int ry;

        // Reset held with toggling input
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        check("rst_locked", int'(locked), 0);
        check("rst_expected", int'(expected), 0);

        // Upstream counter held in reset at 0 for 100 ns
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0, 1'b0);
        check("hold0_locked", int'(locked), 0);

        // Free-running counter: lock after two good increments
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            cnt++;
            step(1'b0, 1'b1, cnt, 1'b0);
        end
        check("lock_locked", int'(locked), 1);

        while (cnt != 15) begin
            cnt++;
            step(1'b0, 1'b1, cnt, 1'b0);
        end
        cnt = 0;
        step(1'b0, 1'b1, cnt, 1'b0);
        check("wrap1_pulse", int'(wrap_pulse), 1);
        check("wrap1_count", int'(wrap_count), 1);
        for (int i = 0; i < 48; i++) begin
            cnt = (cnt + 1) % 16;
            step(1'b0, 1'b1, cnt, 1'b0);
            if (i == 0) check("wrap1_pulse_drop", int'(wrap_pulse), 0);
        end
        check("wrap4_count", int'(wrap_count), 4);

        // Fault: 5 -> 7 -> 9
        while (cnt != 5) begin
            cnt = (cnt + 1) % 16;
            step(1'b0, 1'b1, cnt, 1'b0);
        end
        step(1'b0, 1'b1, 7, 1'b0);
        check("fault_error", int'(error), 1);
        check("fault_locked", int'(locked), 0);
        check("fault_err1", int'(err_count), 1);
        step(1'b0, 1'b1, 9, 1'b0);
        check("fault_err2", int'(err_count), 2);
        check("fault_error_sticky", int'(error), 1);
        check("fault_wrap_hold", int'(wrap_count), 4);

        // Clear and relock
        step(1'b0, 1'b1, 10, 1'b1);
        check("clear_error", int'(error), 0);
        step(1'b0, 1'b1, 11, 1'b0);
        step(1'b0, 1'b1, 12, 1'b0);
        check("relock_locked", int'(locked), 1);
        check("relock_err_hold", int'(err_count), 2);

        // Clear coinciding with a mismatch
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 8, 1'b1);
        check("simul_err", int'(err_count), 4);
        check("simul_error", int'(error), 0);
        check("simul_locked", int'(locked), 0);

        // Enable gating
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        check("gate_err_hold", int'(err_count), 4);
        check("gate_expected_hold", int'(expected), 9);

        // Relock then saturate the error counter
        step(1'b0, 1'b1, 9, 1'b0);
        step(1'b0, 1'b1, 10, 1'b0);
        check("sat_prelock", int'(locked), 1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 10, 1'b0);
        check("sat_err", int'(err_count), 255);

        // Random traffic, mostly in sequence
        for (int i = 0; i < 600; i++) begin
            ry = ($urandom_range(0, 3) != 0) ? (m_prev + 1) % 16 : int'($urandom_range(0, 15));
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0), ry, 1'($urandom_range(0, 15) == 0));
        end

        // Mid-operation reset overrides en and clear_err
        step(1'b1, 1'b1, 5, 1'b1);
        check("midrst_wrap", int'(wrap_count), 0);
        check("midrst_err", int'(err_count), 0);
        check("midrst_expected", int'(expected), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
